decoder_3to8_seq: RTL and testbench

Sequenced 3-to-8 decoder: the receive-side counterpart of the 8-to-3 priority encoder. It accepts a 3-bit code plus group-select flag over a valid/ready handshake and drives the matching one of eight output lines for a programmable number of cycles. An optional idle gap follows each pulse. It reconstructs the request line from an encoder's (Y, GS) pair, e.g. for driving one of eight downstream strobes.

---
 rtl/decoder_pkg.sv | 21 ++
 rtl/dec3to8_comb.sv | 18 +
 rtl/decoder_3to8_seq.sv | 133 +++++++++++++
 tb/tb_decoder_3to8_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequenced 3-to-8 decoder.
// Y polarity follows DECODER_ACTIVE_LOW_EN (defined: 74x138-style active-low lines).
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [LINES-1:0] Y_IDLE = 8'hFF;
`else
  localparam logic [LINES-1:0] Y_IDLE = 8'h00;
`endif

endpackage

// File: rtl/dec3to8_comb.sv
// Pure combinational code-to-line decoder; the selected line takes the
// opposite level of Y_IDLE, so polarity follows DECODER_ACTIVE_LOW_EN.
module dec3to8_comb
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LINES-1:0]  y
);

  logic [LINES-1:0] onehot_s;

  // One-hot select, then flipped into the configured polarity
  always_comb begin
    onehot_s = {{(LINES-1){1'b0}}, 1'b1} << code;
    y        = onehot_s ^ Y_IDLE;
  end

endmodule

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: accepts (A, GS) over valid/ready and drives one
// Y line for HOLD cycles, then an optional GAP; polarity per DECODER_ACTIVE_LOW_EN.
module decoder_3to8_seq
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EI,
  input  logic              VALID,
  input  logic [CODE_W-1:0] A,
  input  logic              GS,
  output logic              READY,
  output logic [LINES-1:0]  Y,
  output logic              ACT,
  output logic              DONE
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP == 0) ? 0 : GAP - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [LINES-1:0]  y_q, y_d;
  logic              act_q, act_d;
  logic              done_q, done_d;
  logic [LINES-1:0]  dec_y;
  logic              accept;

  assign READY  = EI && (state_q == ST_IDLE) && !RST;
  assign accept = VALID && READY;
  assign code_d = accept ? A : code_q;

  dec3to8_comb u_dec (
    .code (code_d),
    .y    (dec_y)
  );

  // Next-state logic; EI low overrides everything and silently returns to idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    act_d   = act_q;
    done_d  = 1'b0;
    if (!EI) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      y_d     = Y_IDLE;
      act_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && GS) begin
            state_d = ST_DRIVE;
            cnt_d   = HOLD_LD;
            y_d     = dec_y;
            act_d   = 1'b1;
          end else if (accept) begin
            done_d  = 1'b1;
            y_d     = Y_IDLE;
            act_d   = 1'b0;
            if (GAP == 0) begin
              state_d = ST_IDLE;
              cnt_d   = 8'd0;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_LD;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == 8'd0) begin
            y_d    = Y_IDLE;
            act_d  = 1'b0;
            done_d = 1'b1;
            if (GAP == 0) begin
              state_d = ST_IDLE;
              cnt_d   = 8'd0;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_LD;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          y_d     = Y_IDLE;
          act_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      code_q  <= 3'd0;
      y_q     <= Y_IDLE;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      y_q     <= y_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  assign Y    = y_q;
  assign ACT  = act_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Self-checking bench: two decoders (HOLD=4/GAP=1 and HOLD=1/GAP=0) on shared
// stimulus, each compared against a timestamp-based transaction model.
module tb_decoder_3to8_seq;

  logic       clk = 1'b0;
  logic       rst, ei, valid, gs;
  logic [2:0] a;
  logic       ready_o [2];
  logic       act_o   [2];
  logic       done_o  [2];
  logic [7:0] y_o     [2];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [7:0] Y_OFF = 8'hFF;
`else
  localparam logic [7:0] Y_OFF = 8'h00;
`endif

  // Model: edge timestamps for end of pulse, DONE edge and return to idle
  int         hold_p  [2] = '{4, 1};
  int         gap_p   [2] = '{1, 0};
  int         now;
  int         idle_at [2];
  int         y_end   [2];
  int         done_at [2];
  logic [2:0] y_line  [2];
  bit         acc     [2];

  always #5 clk = ~clk;

  decoder_3to8_seq #(.HOLD(4), .GAP(1)) u_dut0 (
    .CLK(clk), .RST(rst), .EI(ei), .VALID(valid), .A(a), .GS(gs),
    .READY(ready_o[0]), .Y(y_o[0]), .ACT(act_o[0]), .DONE(done_o[0])
  );

  decoder_3to8_seq #(.HOLD(1), .GAP(0)) u_dut1 (
    .CLK(clk), .RST(rst), .EI(ei), .VALID(valid), .A(a), .GS(gs),
    .READY(ready_o[1]), .Y(y_o[1]), .ACT(act_o[1]), .DONE(done_o[1])
  );

  function automatic logic [7:0] line_pattern(input logic [2:0] n);
    logic [7:0] p;
    p = 8'd0;
    p[n] = 1'b1;
`ifdef DECODER_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        check($sformatf("rst_y%0d", m),     32'(y_o[m]),     32'(Y_OFF));
        check($sformatf("rst_act%0d", m),   32'(act_o[m]),   32'd0);
        check($sformatf("rst_done%0d", m),  32'(done_o[m]),  32'd0);
        check($sformatf("rst_ready%0d", m), 32'(ready_o[m]), 32'd0);
      end else begin
        check($sformatf("y%0d", m),     32'(y_o[m]),
              32'((now <= y_end[m]) ? line_pattern(y_line[m]) : Y_OFF));
        check($sformatf("act%0d", m),   32'(act_o[m]),   32'(now <= y_end[m]));
        check($sformatf("done%0d", m),  32'(done_o[m]),  32'(now == done_at[m]));
        check($sformatf("ready%0d", m), 32'(ready_o[m]), 32'(ei && (now >= idle_at[m])));
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      idle_at[m] = now;
      y_end[m]   = -1;
      done_at[m] = -1;
    end
  endtask

  task automatic model_edge(input int m);
    int k;
    k = now + 1;
    if (!ei) begin
      y_end[m]   = -1;
      done_at[m] = -1;
      idle_at[m] = k;
    end else if (valid && (now >= idle_at[m])) begin
      acc[m] = 1'b1;
      if (gs) begin
        y_line[m]  = a;
        y_end[m]   = k + hold_p[m] - 1;
        done_at[m] = k + hold_p[m];
        idle_at[m] = k + hold_p[m] + gap_p[m];
      end else begin
        y_end[m]   = -1;
        done_at[m] = k;
        idle_at[m] = k + gap_p[m];
      end
    end
  endtask

  task automatic tick();
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    @(posedge clk);
    if (!rst) begin
      model_edge(0);
      model_edge(1);
      now++;
    end
    #1;
    check_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a code until the chosen model instance accepts it
  task automatic send(input logic [2:0] code, input logic g, input int m);
    bit got;
    got   = 1'b0;
    valid = 1'b1;
    a     = code;
    gs    = g;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = acc[m];
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
    valid = 1'b0;
  endtask

  // Asynchronous reset pulse landing mid-cycle
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    now   = 0;
    rst   = 1'b1;
    ei    = 1'b1;
    valid = 1'b0;
    a     = 3'd0;
    gs    = 1'b0;
    y_line[0] = 3'd0;
    y_line[1] = 3'd0;
    model_reset();
    #1;
    check_all();
    idle_n(2);
    rst = 1'b0;
    model_reset();
    idle_n(1);

    send(3'd3, 1'b1, 0);
    idle_n(8);

    send(3'd6, 1'b0, 0);
    idle_n(4);

    send(3'd0, 1'b1, 1);
    send(3'd7, 1'b1, 1);
    send(3'd2, 1'b1, 1);
    idle_n(10);

    send(3'd7, 1'b1, 0);
    idle_n(1);
    ei    = 1'b0;
    valid = 1'b1;
    a     = 3'd4;
    gs    = 1'b1;
    idle_n(3);
    ei = 1'b1;
    tick();
    valid = 1'b0;
    idle_n(8);

    send(3'd5, 1'b1, 0);
    idle_n(1);
    pulse_reset();
    idle_n(3);

    send(3'd2, 1'b1, 0);
    valid = 1'b1;
    a     = 3'd1;
    gs    = 1'b1;
    idle_n(4);
    valid = 1'b0;
    idle_n(6);

    for (int i = 0; i < 600; i++) begin
      ei    = ($urandom_range(0, 19) != 0);
      valid = $urandom_range(0, 1) != 0;
      a     = 3'($urandom_range(0, 7));
      gs    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) pulse_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
